// File: rtl/fifo_burst_reader.sv
// Read-side drain engine for the dual-clock FIFO: pops words in bursts (or a
// timed-out partial burst) and streams them through a 2-entry skid buffer.
module fifo_burst_reader #(
   parameter  int DATA_WIDTH = 8,
   parameter  int FIFO_DEPTH = 16,
   parameter  int BURST_LEN  = 4,
   parameter  int TIMEOUT    = 32,
   localparam int CNT_W      = $clog2(FIFO_DEPTH-1) + 1,
   localparam int TMR_W      = $clog2(TIMEOUT) + 1
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic [CNT_W-1:0]      fifo_rd_count,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  burst_done
);

   typedef enum logic {IDLE, BURST} state_e;

   localparam logic [TMR_W-1:0] TMO  = TMR_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] BLEN = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      beats_q, beats_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic [1:0]            cnt_q, cnt_d;
   // buffer entries hold {last, data}; ent0 is always the head
   logic [DATA_WIDTH:0]   ent0_q, ent0_d, ent1_q, ent1_d;
   logic                  push, pop;
   logic [DATA_WIDTH:0]   new_ent;

   assign m_valid    = (cnt_q != 2'd0);
   assign m_data     = ent0_q[DATA_WIDTH-1:0];
   assign m_last     = ent0_q[DATA_WIDTH];
   assign pop        = m_valid & m_ready;
   assign burst_done = pop & m_last;
   assign busy       = (state_q == BURST) | (cnt_q != 2'd0);
   assign fifo_rd_en = push;
   assign new_ent    = {(beats_q == ONE), fifo_dout};

   always_comb begin
      state_d = state_q;
      beats_d = beats_q;
      tmr_d   = tmr_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_empty)       tmr_d = '0;
            else if (tmr_q != TMO) tmr_d = tmr_q + TMR_W'(1);
            if (enable) begin
               if (fifo_rd_count >= BLEN) begin
                  state_d = BURST;
                  beats_d = BLEN;
                  tmr_d   = '0;
               end else if (!fifo_empty && tmr_q == TMO) begin
                  state_d = BURST;
                  // a lagging count of 0 with data present still drains one word
                  beats_d = (fifo_rd_count == '0) ? ONE : fifo_rd_count;
                  tmr_d   = '0;
               end
            end
         end
         BURST: begin
            // registered state plus fifo_empty only: no path from m_ready
            push = !fifo_empty && (cnt_q != 2'd2);
            if (push) begin
               beats_d = beats_q - ONE;
               if (beats_q == ONE) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      if (pop) ent0_d = ent1_q;
      if (push) begin
         if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) ent0_d = new_ent;
         else                                         ent1_d = new_ent;
      end
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beats_q <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         ent0_q  <= '0;
         ent1_q  <= '0;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue models the FIFO, expected
// beats are queued as words are written and checked as the stream accepts them.
module tb_fifo_burst_reader;
   localparam int DW = 8;
   localparam int CW = 5;

   logic          rd_clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
   logic          fifo_empty = 1'b1, m_ready = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic [CW-1:0] fifo_rd_count = '0;
   logic          fifo_rd_en, m_valid, m_last, busy, burst_done;
   logic [DW-1:0] m_data;

   fifo_burst_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .BURST_LEN(4), .TIMEOUT(32)) dut (
      .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .burst_done(burst_done));

   always #5 rd_clk = ~rd_clk;

   typedef struct packed {logic last; logic [DW-1:0] data;} beat_t;

   logic [DW-1:0] fq[$];
   beat_t         exp_q[$];
   int n_chk = 0, n_pass = 0;
   int n_pop = 0, n_done = 0, n_acc = 0, cyc = 0, cnt_adj = 0, first_v_cyc = -1, cyc0 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic drive_fifo();
      int c;
      c             = fq.size() + cnt_adj;
      fifo_empty    = (fq.size() == 0);
      fifo_dout     = (fq.size() == 0) ? '0 : fq[0];
      fifo_rd_count = CW'(c);
   endtask

   task automatic add(input logic [DW-1:0] d, input logic last);
      beat_t b;
      b.last = last;
      b.data = d;
      fq.push_back(d);
      exp_q.push_back(b);
      drive_fifo();
   endtask

   // one clock: observe at negedge, FIFO model pops on the edge, inputs updated after
   task automatic tick();
      logic  popd;
      beat_t e;
      @(negedge rd_clk);
      popd = fifo_rd_en;
      if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 0);
      if (popd) n_pop++;
      if (burst_done) n_done++;
      if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (m_valid && m_ready) begin
         n_acc++;
         if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
         else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e.data);
            chk("m_last", m_last, e.last);
            chk("burst_done", burst_done, e.last);
         end
      end else chk("burst_done_no_hs", burst_done, 0);
      @(posedge rd_clk);
      #1;
      cyc++;
      if (popd && fq.size() != 0) void'(fq.pop_front());
      drive_fifo();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input string tag);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || busy) && i < 400) begin
         tick();
         i++;
      end
      chk({tag, "_drain_left"}, exp_q.size(), 0);
      chk({tag, "_drain_busy"}, busy, 0);
   endtask

   task automatic clr();
      n_pop = 0; n_done = 0; n_acc = 0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_burst_done", burst_done, 0);
      @(posedge rd_clk); #1;
      rst_n = 1'b1;
      ticks(2);

      // 1: two full bursts back to back
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) add(DW'(8'h10 + i), (i % 4) == 3);
      clr();
      first_v_cyc = -1;
      enable = 1'b1;
      cyc0 = cyc;
      drain("t1");
      chk("t1_first_latency", first_v_cyc - cyc0, 2);
      chk("t1_pops", n_pop, 8);
      chk("t1_dones", n_done, 2);
      chk("t1_beats", n_acc, 8);

      // 2: partial burst flushed by timeout
      clr();
      for (int i = 0; i < 3; i++) add(DW'(8'h20 + i), i == 2);
      ticks(33);
      chk("t2_no_pop_before_timeout", n_pop, 0);
      tick();
      chk("t2_pop_after_timeout", n_pop, 1);
      drain("t2");
      chk("t2_pops", n_pop, 3);
      chk("t2_dones", n_done, 1);

      // 3: backpressure fills the buffer and stops popping
      clr();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) add(DW'(8'h30 + i), i == 3);
      ticks(10);
      chk("t3_pops_held", n_pop, 2);
      chk("t3_rd_en_low", fifo_rd_en, 0);
      chk("t3_m_valid", m_valid, 1);
      chk("t3_m_data_stable", m_data, 8'h30);
      chk("t3_m_last_stable", m_last, 0);
      m_ready = 1'b1;
      drain("t3");
      chk("t3_pops", n_pop, 4);
      chk("t3_dones", n_done, 1);

      // 4: burst committed from a count ahead of the data; engine waits on empty
      clr();
      cnt_adj = 2;
      add(8'h40, 1'b0);
      add(8'h41, 1'b0);
      ticks(12);
      chk("t4_pops_partial", n_pop, 2);
      chk("t4_busy_waiting", busy, 1);
      chk("t4_no_done_yet", n_done, 0);
      cnt_adj = 0;
      add(8'h42, 1'b0);
      add(8'h43, 1'b1);
      drain("t4");
      chk("t4_pops", n_pop, 4);
      chk("t4_dones", n_done, 1);

      // 5: enable dropped mid-burst
      clr();
      for (int i = 0; i < 12; i++) add(DW'(8'h50 + i), (i % 4) == 3);
      for (int i = 0; i < 20 && n_acc < 2; i++) tick();
      enable = 1'b0;
      ticks(20);
      chk("t5_pops_stopped", n_pop, 4);
      chk("t5_beats_stopped", n_acc, 4);
      chk("t5_dones_stopped", n_done, 1);
      chk("t5_fifo_left", fq.size(), 8);
      chk("t5_idle", busy, 0);
      enable = 1'b1;
      drain("t5");
      chk("t5_pops", n_pop, 12);
      chk("t5_dones", n_done, 3);

      // 6: asynchronous reset with a full buffer
      clr();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) add(DW'(8'h60 + i), (i % 4) == 3);
      ticks(6);
      chk("t6_pops_before_rst", n_pop, 2);
      chk("t6_busy_before_rst", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_m_valid", m_valid, 0);
      chk("t6_rst_rd_en", fifo_rd_en, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_m_data", m_data, 0);
      fq.delete();
      exp_q.delete();
      drive_fifo();
      @(posedge rd_clk); #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      clr();
      for (int i = 0; i < 3; i++) add(DW'(8'h70 + i), i == 2);
      ticks(33);
      chk("t6_timer_cleared", n_pop, 0);
      tick();
      chk("t6_timeout_pop", n_pop, 1);
      drain("t6");
      chk("t6_dones", n_done, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
